writeback_queue: RTL

- Buffers register-file write-back requests from the two result producers in the pipeline: the ALU and the data-memory load path.
- Issues the queued requests to the register file one per cycle through its `writeAddress` / `writeData` / `regWrite` write port, in order.
- Writes to the zero register X31 are discarded.
- Offers a read-bypass lookup so the operand-fetch logic can see values that are still queued and not yet written.

---
 rtl/writeback_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Collects register-file write-back requests from the data-memory load path
// and the ALU, and retires them in arrival order through the single register
// file write port, one write per cycle. Requests that target the zero register
// (X31) are accepted but dropped. A combinational bypass lookup lets operand
// fetch see values that are still queued and not yet written.
//
// Ports:
//   CLOCK, RESET                          clock (rising edge), async active-high reset
//   memValid/memReady/memAddress/memData  load result handshake (higher priority)
//   aluValid/aluReady/aluAddress/aluData  ALU result handshake
//   writeAddress/writeData/regWrite       register-file write port (head of queue)
//   lookupAddress/lookupHit/lookupData    bypass search of queued entries
//   pendingCount/full/empty               occupancy status
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     memValid,
    output logic                     memReady,
    input  logic [ADDR_W-1:0]        memAddress,
    input  logic [DATA_W-1:0]        memData,
    input  logic                     aluValid,
    output logic                     aluReady,
    input  logic [ADDR_W-1:0]        aluAddress,
    input  logic [DATA_W-1:0]        aluData,
    output logic [ADDR_W-1:0]        writeAddress,
    output logic [DATA_W-1:0]        writeData,
    output logic                     regWrite,
    input  logic [ADDR_W-1:0]        lookupAddress,
    output logic                     lookupHit,
    output logic [DATA_W-1:0]        lookupData,
    output logic [$clog2(DEPTH):0]   pendingCount,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          memPush;
    logic          aluPush;
    logic          pop;
    logic [1:0]    pushCount;
    logic [PW-1:0] aluSlot;
    logic [PW-1:0] scanIdx;

    // Readiness looks only at the registered count; a pop in the same cycle
    // earns no credit. The ALU needs two free slots when a load is actually
    // being enqueued (X31 loads consume no slot).
    assign memReady = (count < CW'(DEPTH));
    assign memPush  = memValid && memReady && (memAddress != ZERO_REG);
    assign aluReady = memPush ? (count < CW'(DEPTH - 1)) : (count < CW'(DEPTH));
    assign aluPush  = aluValid && aluReady && (aluAddress != ZERO_REG);

    // The register file always accepts, so the head retires whenever present.
    assign pop       = (count != '0);
    assign pushCount = {1'b0, memPush} + {1'b0, aluPush};

    // The load entry is older, so the ALU entry lands one slot behind it.
    assign aluSlot = tail + PW'(memPush);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail  <= tail + PW'(pushCount);
            count <= count + CW'(pushCount) - CW'(pop);
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge CLOCK) begin
        if (memPush) begin
            addrMem[tail] <= memAddress;
            dataMem[tail] <= memData;
        end
        if (aluPush) begin
            addrMem[aluSlot] <= aluAddress;
            dataMem[aluSlot] <= aluData;
        end
    end

    always_comb begin
        regWrite     = 1'b0;
        writeAddress = '0;
        writeData    = '0;
        if (pop) begin
            regWrite     = 1'b1;
            writeAddress = addrMem[head];
            writeData    = dataMem[head];
        end
    end

    // Scan from oldest to youngest so the last match wins; the head entry
    // being written this cycle is still searched.
    always_comb begin
        lookupHit  = 1'b0;
        lookupData = '0;
        scanIdx    = head;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = head + PW'(i);
            if ((CW'(i) < count) && (addrMem[scanIdx] == lookupAddress) &&
                (lookupAddress != ZERO_REG)) begin
                lookupHit  = 1'b1;
                lookupData = dataMem[scanIdx];
            end
        end
    end

    assign pendingCount = count;
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);

endmodule
